// File: rtl/voice_mix_panner_if.sv
// Voice mixer/panner bus: voice samples and pan controls in, stereo frame out.
interface voice_mix_panner_if #(
    parameter int unsigned NUM_VOICES = 8
);
    logic                           lrck;
    logic [NUM_VOICES*16-1:0]       voice_in;
    logic [7:0]                     pan_in;
    logic                           auto_pan_en;
    logic [15:0]                    auto_rate;
    logic signed [15:0]             l_out;
    logic signed [15:0]             r_out;
    logic                           out_valid;
    logic [7:0]                     pan_mon;
    logic                           overrun;

    // Mixer side
    modport slave (
        input  lrck, voice_in, pan_in, auto_pan_en, auto_rate,
        output l_out, r_out, out_valid, pan_mon, overrun
    );

    // Source/sink side
    modport master (
        output lrck, voice_in, pan_in, auto_pan_en, auto_rate,
        input  l_out, r_out, out_valid, pan_mon, overrun
    );
endinterface

// File: rtl/voice_mix_panner.sv
// Per-frame voice mixer with saturating scale and linear stereo panning.
// Pan source is the manual pan value or an internal triangle LFO.
// Optional macro PAN_SMOOTH_EN: pan slews toward its target by at most 1 per frame.
module voice_mix_panner #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned MIX_SHIFT  = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    voice_mix_panner_if.slave bus
);
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned ACC_W    = SAMPLE_W + IDX_W;
    localparam int unsigned PROD_W   = SAMPLE_W + 9;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SCALE,
        ST_OUTPUT
    } state_e;

    state_e                     state_q, state_d;
    logic                       sync1_q, sync2_q, hist_q;
    logic                       edge_c;
    logic [IDX_W-1:0]           vidx_q, vidx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] snap_q [NUM_VOICES];
    logic signed [SAMPLE_W-1:0] snap_d [NUM_VOICES];
    logic [7:0]                 pan_eff_q, pan_eff_d;
    logic [7:0]                 lfo_q, lfo_d;
    logic                       lfo_up_q, lfo_up_d;
    logic [15:0]                rate_cnt_q, rate_cnt_d;
    logic signed [SAMPLE_W-1:0] l_out_q, l_out_d;
    logic signed [SAMPLE_W-1:0] r_out_q, r_out_d;
    logic                       out_valid_q, out_valid_d;
    logic [7:0]                 pan_mon_q, pan_mon_d;
    logic                       overrun_q, overrun_d;
`ifdef PAN_SMOOTH_EN
    logic [7:0]                 pan_sm_q, pan_sm_d;
`endif

    logic [15:0]                rate_eff;
    logic [16:0]                cnt_inc;
    logic [7:0]                 pan_src;
    logic [7:0]                 pan_sel;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [SAMPLE_W-1:0] mix;
    logic signed [SAMPLE_W-1:0] cur_snap;
    logic signed [8:0]          gl_s, gr_s;
    logic signed [PROD_W-1:0]   prod_l, prod_r;

    // Bring lrck into the Clk domain and keep one cycle of history for edge detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= bus.lrck;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign edge_c = sync2_q & ~hist_q;

    // Frame sequencer, mixing datapath, LFO and sticky overrun flag
    always_comb begin
        state_d     = state_q;
        vidx_d      = vidx_q;
        acc_d       = acc_q;
        snap_d      = snap_q;
        pan_eff_d   = pan_eff_q;
        lfo_d       = lfo_q;
        lfo_up_d    = lfo_up_q;
        rate_cnt_d  = rate_cnt_q;
        l_out_d     = l_out_q;
        r_out_d     = r_out_q;
        out_valid_d = 1'b0;
        pan_mon_d   = pan_mon_q;
        overrun_d   = overrun_q;
`ifdef PAN_SMOOTH_EN
        pan_sm_d    = pan_sm_q;
`endif

        rate_eff = (bus.auto_rate == 16'd0) ? 16'd1 : bus.auto_rate;
        cnt_inc  = {1'b0, rate_cnt_q} + 17'd1;
        pan_src  = bus.auto_pan_en ? lfo_q : bus.pan_in;
`ifdef PAN_SMOOTH_EN
        if (pan_src > pan_sm_q) begin
            pan_sel = pan_sm_q + 8'd1;
        end else if (pan_src < pan_sm_q) begin
            pan_sel = pan_sm_q - 8'd1;
        end else begin
            pan_sel = pan_sm_q;
        end
`else
        pan_sel = pan_src;
`endif

        cur_snap = snap_q[vidx_q];
        shifted  = acc_q >>> MIX_SHIFT;
        if (shifted > SAT_MAX) begin
            mix = 16'sh7FFF;
        end else if (shifted < SAT_MIN) begin
            mix = 16'sh8000;
        end else begin
            mix = SAMPLE_W'(shifted);
        end
        gl_s   = {1'b0, ~pan_eff_q};
        gr_s   = {1'b0, pan_eff_q};
        prod_l = PROD_W'(mix) * PROD_W'(gl_s);
        prod_r = PROD_W'(mix) * PROD_W'(gr_s);

        if (edge_c && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (edge_c) begin
                    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                        snap_d[i] = bus.voice_in[SAMPLE_W*i +: SAMPLE_W];
                    end
                    pan_eff_d = pan_sel;
`ifdef PAN_SMOOTH_EN
                    pan_sm_d  = pan_sel;
`endif
                    acc_d     = '0;
                    vidx_d    = '0;
                    state_d   = ST_ACCUM;
                    // LFO advances after this frame's pan has been captured
                    if (bus.auto_pan_en) begin
                        if (cnt_inc >= {1'b0, rate_eff}) begin
                            rate_cnt_d = '0;
                            if (lfo_up_q) begin
                                if (lfo_q == 8'd255) begin
                                    lfo_d    = 8'd254;
                                    lfo_up_d = 1'b0;
                                end else begin
                                    lfo_d = lfo_q + 8'd1;
                                end
                            end else begin
                                if (lfo_q == 8'd0) begin
                                    lfo_d    = 8'd1;
                                    lfo_up_d = 1'b1;
                                end else begin
                                    lfo_d = lfo_q - 8'd1;
                                end
                            end
                        end else begin
                            rate_cnt_d = cnt_inc[15:0];
                        end
                    end
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + {{(ACC_W-SAMPLE_W){cur_snap[SAMPLE_W-1]}}, cur_snap};
                if (vidx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = ST_SCALE;
                end else begin
                    vidx_d = vidx_q + IDX_W'(1);
                end
            end
            ST_SCALE: begin
                l_out_d     = SAMPLE_W'(prod_l >>> 8);
                r_out_d     = SAMPLE_W'(prod_r >>> 8);
                pan_mon_d   = pan_eff_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            vidx_q      <= '0;
            acc_q       <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                snap_q[i] <= '0;
            end
            pan_eff_q   <= '0;
            lfo_q       <= '0;
            lfo_up_q    <= 1'b1;
            rate_cnt_q  <= '0;
            l_out_q     <= '0;
            r_out_q     <= '0;
            out_valid_q <= 1'b0;
            pan_mon_q   <= '0;
            overrun_q   <= 1'b0;
`ifdef PAN_SMOOTH_EN
            pan_sm_q    <= 8'd128;
`endif
        end else begin
            state_q     <= state_d;
            vidx_q      <= vidx_d;
            acc_q       <= acc_d;
            snap_q      <= snap_d;
            pan_eff_q   <= pan_eff_d;
            lfo_q       <= lfo_d;
            lfo_up_q    <= lfo_up_d;
            rate_cnt_q  <= rate_cnt_d;
            l_out_q     <= l_out_d;
            r_out_q     <= r_out_d;
            out_valid_q <= out_valid_d;
            pan_mon_q   <= pan_mon_d;
            overrun_q   <= overrun_d;
`ifdef PAN_SMOOTH_EN
            pan_sm_q    <= pan_sm_d;
`endif
        end
    end

    assign bus.l_out     = l_out_q;
    assign bus.r_out     = r_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pan_mon   = pan_mon_q;
    assign bus.overrun   = overrun_q;

endmodule
